// File: rtl/base_ram_arbiter.sv
// Registered arbiter/sequencer for the shared BaseRAM SRAM: instruction fetch (IF)
// and data-side accesses to 0x80000000-0x803FFFFF (MEM, fixed priority) on one device.
module base_ram_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int WE_CYCLES   = 1
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        busy_o,
  inout  wire  [31:0] base_ram_data,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n
);

  // Handshake: a requester holds req (and, for MEM, addr/data/sel/we) high until it
  // sees a one-cycle ready pulse, and drops or replaces req in that same cycle.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [2:0] RD_LAST = 3'(WAIT_CYCLES);
  localparam logic [2:0] WE_LAST = 3'(WE_CYCLES - 1);

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        port_mem, port_mem_nx;
  logic [19:0] addr_q, addr_nx;
  logic [3:0]  be_q, be_nx;
  logic        ce_q, ce_nx;
  logic        oe_q, oe_nx;
  logic        we_q, we_nx;
  logic [31:0] dout_q, dout_nx;
  logic        doe_q, doe_nx;
  logic [31:0] if_rdata_q, if_rdata_nx;
  logic [31:0] mem_rdata_q, mem_rdata_nx;
  logic        if_ready_q, if_ready_nx;
  logic        mem_ready_q, mem_ready_nx;
  logic        mem_valid;

  assign mem_valid = mem_req && (mem_addr[31:22] == 10'h200);

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    port_mem_nx  = port_mem;
    addr_nx      = addr_q;
    be_nx        = be_q;
    ce_nx        = ce_q;
    oe_nx        = oe_q;
    we_nx        = we_q;
    dout_nx      = dout_q;
    doe_nx       = doe_q;
    if_rdata_nx  = if_rdata_q;
    mem_rdata_nx = mem_rdata_q;
    if_ready_nx  = 1'b0;
    mem_ready_nx = 1'b0;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          port_mem_nx = 1'b1;
          addr_nx     = mem_addr[21:2];
          cnt_nx      = 3'd0;
          ce_nx       = 1'b0;
          we_nx       = 1'b1;
          if (mem_we) begin
            state_nx = WR_SETUP;
            be_nx    = ~mem_sel;
            oe_nx    = 1'b1;
            dout_nx  = mem_wdata;
            doe_nx   = 1'b1;
          end else begin
            state_nx = RD;
            be_nx    = 4'h0;
            oe_nx    = 1'b0;
          end
        end else if (if_req) begin
          port_mem_nx = 1'b0;
          state_nx    = RD;
          addr_nx     = if_addr[21:2];
          cnt_nx      = 3'd0;
          be_nx       = 4'h0;
          ce_nx       = 1'b0;
          oe_nx       = 1'b0;
          we_nx       = 1'b1;
        end
      end
      RD: begin
        if (cnt == RD_LAST) begin
          if (port_mem) begin
            mem_rdata_nx = base_ram_data;
            mem_ready_nx = 1'b1;
          end else begin
            if_rdata_nx = base_ram_data;
            if_ready_nx = 1'b1;
          end
          state_nx = DONE;
          ce_nx    = 1'b1;
          oe_nx    = 1'b1;
          we_nx    = 1'b1;
          be_nx    = 4'hF;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      WR_SETUP: begin
        state_nx = WR_PULSE;
        we_nx    = 1'b0;
        cnt_nx   = 3'd0;
      end
      WR_PULSE: begin
        if (cnt == WE_LAST) begin
          state_nx = WR_HOLD;
          we_nx    = 1'b1;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      WR_HOLD: begin
        // Address, byte enables and data stay put through this cycle for hold time.
        state_nx     = DONE;
        mem_ready_nx = 1'b1;
        ce_nx        = 1'b1;
        oe_nx        = 1'b1;
        we_nx        = 1'b1;
        be_nx        = 4'hF;
        doe_nx       = 1'b0;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      port_mem    <= 1'b0;
      addr_q      <= 20'd0;
      be_q        <= 4'hF;
      ce_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      dout_q      <= 32'd0;
      doe_q       <= 1'b0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      port_mem    <= port_mem_nx;
      addr_q      <= addr_nx;
      be_q        <= be_nx;
      ce_q        <= ce_nx;
      oe_q        <= oe_nx;
      we_q        <= we_nx;
      dout_q      <= dout_nx;
      doe_q       <= doe_nx;
      if_rdata_q  <= if_rdata_nx;
      mem_rdata_q <= mem_rdata_nx;
      if_ready_q  <= if_ready_nx;
      mem_ready_q <= mem_ready_nx;
    end
  end

  assign base_ram_data = doe_q ? dout_q : 32'bz;
  assign base_ram_addr = addr_q;
  assign base_ram_be_n = be_q;
  assign base_ram_ce_n = ce_q;
  assign base_ram_oe_n = oe_q;
  assign base_ram_we_n = we_q;
  assign if_rdata      = if_rdata_q;
  assign if_ready      = if_ready_q;
  assign mem_rdata     = mem_rdata_q;
  assign mem_ready     = mem_ready_q;
  assign busy_o        = (state != IDLE);

  // Byte-offset and region bits that the SRAM word address does not need.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:22], if_addr[1:0], mem_addr[1:0]};

endmodule

// File: tb/tb_base_ram_arbiter.sv
// Bench for base_ram_arbiter: SRAM model on the bus, directed sequences, a vector
// table and randomized traffic checked against a shadow-memory reference.
module tb_base_ram_arbiter;

  localparam int WAITC = 1;
  localparam int WEC   = 1;

  logic        clk_50M;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy_o;
  wire  [31:0] base_ram_data;
  logic [19:0] base_ram_addr;
  logic [3:0]  base_ram_be_n;
  logic        base_ram_ce_n;
  logic        base_ram_oe_n;
  logic        base_ram_we_n;

  base_ram_arbiter #(.WAIT_CYCLES(WAITC), .WE_CYCLES(WEC)) dut (
    .clk_50M(clk_50M), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy_o(busy_o),
    .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr),
    .base_ram_be_n(base_ram_be_n), .base_ram_ce_n(base_ram_ce_n),
    .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n)
  );

  // ---------------- clock ----------------
  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  // An undriven bus reads as all ones.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pu
      pullup (base_ram_data[gi]);
    end
  endgenerate

  // ---------------- SRAM model ----------------
  function automatic logic [31:0] init_word(input int i);
    case (i)
      4:       return 32'h3C08_8040;
      8:       return 32'h1122_3344;
      64:      return 32'h0BAD_F00D;
      default: return 32'h5A00_0000 | 32'(i);
    endcase
  endfunction

  logic [31:0] sram [0:1023];
  logic        load_en;
  logic        sram_drive;
  logic [31:0] sram_word;

  assign sram_drive = !base_ram_ce_n && !base_ram_oe_n && base_ram_we_n;
  assign sram_word  = sram[base_ram_addr[9:0]];
  assign base_ram_data = sram_drive ? sram_word : 32'bz;

  always @(posedge clk_50M) begin
    if (load_en) begin
      for (int i = 0; i < 1024; i++) sram[i] <= init_word(i);
    end else if (!base_ram_ce_n && !base_ram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!base_ram_be_n[b]) sram[base_ram_addr[9:0]][8*b +: 8] <= base_ram_data[8*b +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] shadow [0:1023];
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) shadow[a[11:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  // A write strobe must never overlap an output enable and always has chip enable.
  always @(negedge clk_50M) begin
    if (!rst && base_ram_we_n === 1'b0) begin
      check("we_with_ce", {31'd0, base_ram_ce_n}, 32'd0);
      check("we_without_oe", {31'd0, base_ram_oe_n}, 32'd1);
    end
  end

  // ---------------- driver ----------------
  task automatic run_pair(input bit do_if, input logic [31:0] ia,
                          input bit do_mem, input bit mwe, input logic [31:0] ma,
                          input logic [31:0] mwd, input logic [3:0] msel,
                          output int if_lat, output int mem_lat,
                          output logic [31:0] if_d, output logic [31:0] mem_d,
                          output int if_cnt, output int mem_cnt);
    bit mem_ok;
    int done_cyc;
    mem_ok = do_mem && (ma[31:22] == 10'h200);
    if_lat = -1; mem_lat = -1; if_d = 32'd0; mem_d = 32'd0;
    if_cnt = 0; mem_cnt = 0; done_cyc = -1;
    @(negedge clk_50M);
    if_req = do_if; if_addr = ia;
    mem_req = do_mem; mem_we = mwe; mem_addr = ma; mem_wdata = mwd; mem_sel = msel;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk_50M);
      if (if_ready) begin
        if_cnt++;
        if (if_lat < 0) begin if_lat = cyc; if_d = if_rdata; end
        if_req = 1'b0;
      end
      if (mem_ready) begin
        mem_cnt++;
        if (mem_lat < 0) begin mem_lat = cyc; mem_d = mem_rdata; end
        mem_req = 1'b0;
      end
      if (done_cyc < 0 && (!do_if || if_lat >= 0) && (!mem_ok || mem_lat >= 0)) done_cyc = cyc;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    if_req = 1'b0;
    mem_req = 1'b0;
  endtask

  task automatic invalid_idle(input logic [31:0] ma, input int n);
    int pulses;
    pulses = 0;
    @(negedge clk_50M);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = ma;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50M);
      check("invalid_busy", {31'd0, busy_o}, 32'd0);
      if (mem_ready) pulses++;
    end
    check("invalid_no_ready", pulses, 0);
    mem_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ce_n"}, {31'd0, base_ram_ce_n}, 32'd1);
    check({tag, "_oe_n"}, {31'd0, base_ram_oe_n}, 32'd1);
    check({tag, "_we_n"}, {31'd0, base_ram_we_n}, 32'd1);
    check({tag, "_be_n"}, {28'd0, base_ram_be_n}, 32'hF);
    check({tag, "_addr"}, {12'd0, base_ram_addr}, 32'd0);
    check({tag, "_bus"}, base_ram_data, 32'hFFFF_FFFF);
    check({tag, "_if_ready"}, {31'd0, if_ready}, 32'd0);
    check({tag, "_mem_ready"}, {31'd0, mem_ready}, 32'd0);
    check({tag, "_if_rdata"}, if_rdata, 32'd0);
    check({tag, "_mem_rdata"}, mem_rdata, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vt [8];

  int          il, ml, ic, mc;
  logic [31:0] idat, mdat;

  initial begin
    vt[0] = '{0, 0, 32'h8000_0010, 32'h0,         4'h0, 32'h3C08_8040, WAITC + 2};
    vt[1] = '{1, 0, 32'h8000_0020, 32'h0,         4'h0, 32'h1122_BEEF, WAITC + 2};
    vt[2] = '{1, 1, 32'h8000_0024, 32'hAABB_CCDD, 4'hF, 32'h0,         WEC + 3};
    vt[3] = '{0, 0, 32'h8000_0026, 32'h0,         4'h0, 32'hAABB_CCDD, WAITC + 2};
    vt[4] = '{1, 1, 32'h8000_0024, 32'h1234_5678, 4'h8, 32'h0,         WEC + 3};
    vt[5] = '{1, 0, 32'h8000_0027, 32'h0,         4'h0, 32'h12BB_CCDD, WAITC + 2};
    vt[6] = '{1, 1, 32'h8000_0028, 32'hCAFE_1234, 4'h4, 32'h0,         WEC + 3};
    vt[7] = '{0, 0, 32'h8000_0028, 32'h0,         4'h0, 32'h5AFE_000A, WAITC + 2};

    for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);

    // ---------------- reset ----------------
    rst = 1'b1; load_en = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_sel = 4'h0;
    repeat (3) @(negedge clk_50M);
    load_en = 1'b0;
    @(negedge clk_50M);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk_50M);
    check_reset_outputs("idle");

    // ---------------- directed IF read ----------------
    if_req = 1'b1; if_addr = 32'h8000_0010;
    @(negedge clk_50M);
    check("ifrd_addr", {12'd0, base_ram_addr}, 32'h4);
    check("ifrd_oe_t0", {31'd0, base_ram_oe_n}, 32'd0);
    check("ifrd_ce_t0", {31'd0, base_ram_ce_n}, 32'd0);
    @(negedge clk_50M);
    check("ifrd_ready_early", {31'd0, if_ready}, 32'd0);
    check("ifrd_oe_t1", {31'd0, base_ram_oe_n}, 32'd0);
    @(negedge clk_50M);
    check("ifrd_ready", {31'd0, if_ready}, 32'd1);
    check("ifrd_data", if_rdata, 32'h3C08_8040);
    check("ifrd_done_oe", {31'd0, base_ram_oe_n}, 32'd1);
    if_req = 1'b0;
    @(negedge clk_50M);
    check("ifrd_ready_once", {31'd0, if_ready}, 32'd0);
    check("ifrd_idle", {31'd0, busy_o}, 32'd0);

    // ---------------- directed MEM write ----------------
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0020;
    mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'b0011;
    @(negedge clk_50M);
    check("wr_setup_we", {31'd0, base_ram_we_n}, 32'd1);
    check("wr_setup_oe", {31'd0, base_ram_oe_n}, 32'd1);
    check("wr_setup_be", {28'd0, base_ram_be_n}, 32'hC);
    check("wr_setup_addr", {12'd0, base_ram_addr}, 32'h8);
    check("wr_setup_bus", base_ram_data, 32'hDEAD_BEEF);
    check("wr_setup_busy", {31'd0, busy_o}, 32'd1);
    @(negedge clk_50M);
    check("wr_pulse_we", {31'd0, base_ram_we_n}, 32'd0);
    check("wr_pulse_be", {28'd0, base_ram_be_n}, 32'hC);
    check("wr_pulse_bus", base_ram_data, 32'hDEAD_BEEF);
    @(negedge clk_50M);
    check("wr_hold_we", {31'd0, base_ram_we_n}, 32'd1);
    check("wr_hold_ce", {31'd0, base_ram_ce_n}, 32'd0);
    check("wr_hold_bus", base_ram_data, 32'hDEAD_BEEF);
    check("wr_hold_ready", {31'd0, mem_ready}, 32'd0);
    @(negedge clk_50M);
    check("wr_ready", {31'd0, mem_ready}, 32'd1);
    check("wr_done_ce", {31'd0, base_ram_ce_n}, 32'd1);
    check("wr_done_bus", base_ram_data, 32'hFFFF_FFFF);
    check("wr_sram_word", sram[8], 32'h1122_BEEF);
    mem_req = 1'b0;
    apply_write(32'h8000_0020, 32'hDEAD_BEEF, 4'b0011);
    @(negedge clk_50M);
    check("wr_ready_once", {31'd0, mem_ready}, 32'd0);

    // ---------------- table ----------------
    foreach (vt[k]) begin
      run_pair(!vt[k].is_mem, vt[k].addr, vt[k].is_mem, vt[k].we, vt[k].addr,
               vt[k].wdata, vt[k].sel, il, ml, idat, mdat, ic, mc);
      if (vt[k].is_mem) begin
        check($sformatf("vec%0d_lat", k), ml, vt[k].exp_lat);
        check($sformatf("vec%0d_pulses", k), mc, 1);
        if (!vt[k].we) check($sformatf("vec%0d_data", k), mdat, vt[k].exp_rdata);
        else apply_write(vt[k].addr, vt[k].wdata, vt[k].sel);
      end else begin
        check($sformatf("vec%0d_lat", k), il, vt[k].exp_lat);
        check($sformatf("vec%0d_pulses", k), ic, 1);
        check($sformatf("vec%0d_data", k), idat, vt[k].exp_rdata);
      end
    end

    // ---------------- simultaneous requests ----------------
    run_pair(1, 32'h8000_0010, 1, 0, 32'h8000_0100, 32'h0, 4'h0, il, ml, idat, mdat, ic, mc);
    check("arb_mem_lat", ml, WAITC + 2);
    check("arb_mem_data", mdat, 32'h0BAD_F00D);
    check("arb_if_gap", il - ml, WAITC + 3);
    check("arb_if_data", idat, 32'h3C08_8040);
    check("arb_pulses", ic + mc, 2);

    // ---------------- out-of-region MEM request ----------------
    run_pair(1, 32'h8000_0010, 1, 0, 32'h8040_0000, 32'h0, 4'h0, il, ml, idat, mdat, ic, mc);
    check("oor_if_lat", il, WAITC + 2);
    check("oor_if_data", idat, 32'h3C08_8040);
    check("oor_mem_pulses", mc, 0);
    invalid_idle(32'h8040_0000, 5);

    // ---------------- reset during write pulse ----------------
    @(negedge clk_50M);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0040;
    mem_wdata = 32'h5555_5555; mem_sel = 4'hF;
    @(negedge clk_50M);
    @(negedge clk_50M);
    check("rstwr_in_pulse", {31'd0, base_ram_we_n}, 32'd0);
    rst = 1'b1;
    @(negedge clk_50M);
    check("rstwr_we_n", {31'd0, base_ram_we_n}, 32'd1);
    check("rstwr_ce_n", {31'd0, base_ram_ce_n}, 32'd1);
    check("rstwr_bus", base_ram_data, 32'hFFFF_FFFF);
    check("rstwr_busy", {31'd0, busy_o}, 32'd0);
    rst = 1'b0; mem_req = 1'b0;
    ic = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_50M);
      if (mem_ready || if_ready) ic++;
    end
    check("rstwr_no_ready", ic, 0);
    run_pair(1, 32'h8000_0010, 0, 0, 32'h0, 32'h0, 4'h0, il, ml, idat, mdat, ic, mc);
    check("rstwr_if_lat", il, WAITC + 2);
    check("rstwr_if_data", idat, 32'h3C08_8040);

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 60; n++) begin
      int          op, exp_ml, exp_il;
      bit          d_if, d_mem, mwe, mok;
      logic [31:0] ia, ma, wd;
      logic [3:0]  sl;
      logic [9:0]  hi;
      op  = $urandom_range(0, 3);
      ia  = 32'h8000_0000 | (32'($urandom_range(65, 1023)) << 2) | 32'($urandom_range(0, 3));
      ma  = 32'h8000_0000 | (32'($urandom_range(65, 1023)) << 2) | 32'($urandom_range(0, 3));
      wd  = $urandom;
      sl  = 4'($urandom_range(0, 15));
      mwe = 1'($urandom_range(0, 1));
      d_if  = (op != 1);
      d_mem = (op != 0);
      if (op == 3) begin
        hi = 10'($urandom_range(0, 1023));
        if (hi == 10'h200) hi = 10'h201;
        ma = {hi, ma[21:0]};
      end
      mok = d_mem && (ma[31:22] == 10'h200);
      // MEM takes effect before IF; the expected read data follows that order.
      if (mok) begin
        if (mwe) apply_write(ma, wd, sl);
        else exp_q.push_back(shadow[ma[11:2]]);
      end
      if (d_if) exp_q.push_back(shadow[ia[11:2]]);
      exp_ml = mwe ? WEC + 3 : WAITC + 2;
      exp_il = (mok ? exp_ml + 1 : 0) + WAITC + 2;
      run_pair(d_if, ia, d_mem, mwe, ma, wd, sl, il, ml, idat, mdat, ic, mc);
      if (mok) begin
        check($sformatf("rnd%0d_mem_lat", n), ml, exp_ml);
        if (!mwe) check($sformatf("rnd%0d_mem_data", n), mdat, exp_q.pop_front());
      end
      check($sformatf("rnd%0d_mem_pulses", n), mc, mok ? 1 : 0);
      if (d_if) begin
        check($sformatf("rnd%0d_if_lat", n), il, exp_il);
        check($sformatf("rnd%0d_if_data", n), idat, exp_q.pop_front());
      end
      check($sformatf("rnd%0d_if_pulses", n), ic, d_if ? 1 : 0);
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
